regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port general-purpose register file for the MIPS core's ID stage, replacing the fixed 2-read/32x32 register file. It adds configurable width, depth and read-port count, a hardware clear sequence after reset, and a per-register busy scoreboard for load-use hazard detection. Read data is returned combinationally to the decode stage; writes arrive from WB.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W
- NREAD, 2, number of read ports (1..4)
- ZERO_REG, 1, if 1 register 0 reads as zero and ignores writes/busy marks

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- we  in  1  write enable (WB)
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- re  in  NREAD  per-port read enable
- raddr  in  NREAD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rdata  out  NREAD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- busy_set  in  1  mark busy_addr as having an outstanding producer (issue of load)
- busy_addr  in  ADDR_W  register to mark busy
- rbusy  out  NREAD  per-port: addressed register has outstanding producer
- ready  out  1  clear sequence done; file accepts writes/reads

## Operation
- FSM states: INIT, RUN. rst low at a clock edge: state<=INIT, clear pointer<=0, all busy bits<=0.
- INIT (rst high): each cycle regs[ptr]<=0, ptr<=ptr+1; when ptr==DEPTH-1, state<=RUN. we and busy_set ignored.
- RUN: write regs[waddr]<=wdata when we=1, except waddr==0 with ZERO_REG=1.
- Read port i (combinational): rdata_i=0 if ready=0, re[i]=0, or (ZERO_REG and raddr_i==0); else bypassed wdata if REGFILE_BYPASS_EN and we=1 and waddr==raddr_i; else regs[raddr_i].
- Scoreboard (RUN only): busy[busy_addr]<=1 on busy_set; busy[waddr]<=0 on we. Same address both in one cycle: set wins. ZERO_REG=1: busy[0] never set.
- rbusy[i] = ready & re[i] & busy[raddr_i], masked to 0 when bypass is compiled in and we=1 with waddr==raddr_i.
- ready = (state==RUN), registered.

## Timing
- Reset values: ready=0, rdata=all 0, rbusy=all 0, busy bits 0.
- ready rises exactly DEPTH rising edges after the first edge sampling rst=1 (32 cycles at default).
- rst low mid-RUN: next edge returns to INIT; contents cleared again; pending busy marks lost.
- Write latency: written data visible via regs on cycle after the write edge; same-cycle only via bypass.
- Read-port combinational path: raddr/we/waddr/wdata -> rdata, no registers.
- Multiple read ports hitting same address see identical data.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle write-to-read forwarding on every port, rbusy masked for the register being written.
- Undefined: reads return stored value only (old data on same-cycle hit); rbusy reports busy until the edge after the write.

## Structure
- regfile_pkg: default DATA_W/ADDR_W/NREAD constants, state enum (INIT, RUN), address/data typedefs.
- One sub-module: regfile_scoreboard (DEPTH busy bits, set/clear priority, NREAD lookup ports); storage, FSM and read muxes stay in regfile_mp.

## Test plan
- Reset release, default params: ready=0 for 32 cycles, 1 on cycle 32; all reads of 1..31 return 0x00000000.
- we=1, waddr=5, wdata=0xDEADBEEF, raddr0=5 same cycle: rdata0=0xDEADBEEF with macro, previous value (0) without; next cycle 0xDEADBEEF both builds.
- Write 0x12345678 to r0 then read r0 on both ports: 0 always; busy_set on r0 leaves rbusy=0.
- busy_set r8, read r8 -> rbusy0=1; busy_set r8 and we r8 same cycle -> rbusy stays 1 next cycle; lone we r8 -> rbusy 0 after edge.
- During RUN with r3=0xA5A5A5A5, drive rst low one cycle: ready=0 next cycle, re-init 32 cycles, r3 reads 0, all busy clear.
- NREAD=4, DATA_W=64: four distinct addresses read concurrently return the four stored 64-bit values; re[2]=0 yields 0 on port 2.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
package regfile_pkg;

    localparam int REGFILE_DATA_W = 32;
    localparam int REGFILE_ADDR_W = 5;
    localparam int REGFILE_NREAD  = 2;

    // INIT walks the clear pointer over every register; RUN is normal operation.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;
    typedef logic [REGFILE_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for load-use hazard detection, with NREAD lookup ports.
// A set and a clear to the same register in one cycle leaves it busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = REGFILE_ADDR_W,
    parameter int NREAD    = REGFILE_NREAD,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    set_en,
    input  logic [ADDR_W-1:0]       set_addr,
    input  logic                    clr_en,
    input  logic [ADDR_W-1:0]       clr_addr,
    input  logic [NREAD*ADDR_W-1:0] look_addr,
    output logic [NREAD-1:0]        look_busy
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DEPTH-1:0] busy_reg;
    logic             set_ok;

    // Register 0 never becomes busy when it is hardwired to zero.
    assign set_ok = set_en && !(ZERO_EN && (set_addr == '0));

    // Busy bit update: clear on write-back, set on load issue; the later set wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_reg <= '0;
        end else if (run) begin
            if (clr_en) begin
                busy_reg[clr_addr] <= 1'b0;
            end
            if (set_ok) begin
                busy_reg[set_addr] <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_look
            assign look_busy[gi] = busy_reg[look_addr[gi*ADDR_W +: ADDR_W]];
        end
    endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with post-reset clear sequence
// and busy scoreboard. Reads are combinational; writes land on the rising edge.
// Optional feature macro: REGFILE_BYPASS_EN forwards the in-flight write to
// every read port and hides the busy flag of the register being written.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REGFILE_DATA_W,
    parameter int ADDR_W   = REGFILE_ADDR_W,
    parameter int NREAD    = REGFILE_NREAD,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [NREAD-1:0]        re,
    input  logic [NREAD*ADDR_W-1:0] raddr,
    output logic [NREAD*DATA_W-1:0] rdata,
    input  logic                    busy_set,
    input  logic [ADDR_W-1:0]       busy_addr,
    output logic [NREAD-1:0]        rbusy,
    output logic                    ready
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr_reg;
    logic [ADDR_W-1:0] ptr_next;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              zero_waddr;
    logic [NREAD-1:0]  sb_busy;

    // State and clear-pointer registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= INIT;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Next state: INIT advances the clear pointer and leaves after the last register.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            INIT: begin
                ptr_next = ptr_reg + 1'b1;
                if (ptr_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = RUN;
                end
            end
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    assign ready      = (state_reg == RUN);
    assign zero_waddr = ZERO_EN && (waddr == '0);

    // Storage write: clear sequence during INIT, write-back port during RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_reg == INIT) begin
                regs[ptr_reg] <= '0;
            end else if (we && !zero_waddr) begin
                regs[waddr] <= wdata;
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NREAD    (NREAD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .run       (ready),
        .set_en    (busy_set),
        .set_addr  (busy_addr),
        .clr_en    (we),
        .clr_addr  (waddr),
        .look_addr (raddr),
        .look_busy (sb_busy)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic              hit;
            logic [DATA_W-1:0] rd;

            assign ra = raddr[gi*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
            assign hit = we && (waddr == ra);
`else
            assign hit = 1'b0;
`endif

            // Read mux: gated zero, then forwarded write data, then stored value.
            always_comb begin
                rd = '0;
                if (ready && re[gi] && !(ZERO_EN && (ra == '0))) begin
                    rd = hit ? wdata : regs[ra];
                end
            end

            assign rdata[gi*DATA_W +: DATA_W] = rd;
            assign rbusy[gi] = ready & re[gi] & sb_busy[gi] & ~hit;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (NREAD=4, DATA_W=64, ADDR_W=5, ZERO_REG=1).
// Honours REGFILE_BYPASS_EN when defined for the build.
module tb_regfile_mp;

    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int NR    = 4;
    localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic             busy_set;
    logic [AW-1:0]    busy_addr;
    logic [NR-1:0]    rbusy;
    logic             ready;

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NREAD    (NR),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .re        (re),
        .raddr     (raddr),
        .rdata     (rdata),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .rbusy     (rbusy),
        .ready     (ready)
    );

    typedef struct {
        logic             rdy;
        logic [NR-1:0]    rb;
        logic [NR*DW-1:0] rd;
    } exp_t;

    exp_t q[$];

    // Reference model: register contents, busy flags and readiness.
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];
    bit            m_ready;
    int            m_cnt;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    // One cycle of stimulus: drive, predict outputs, push, then advance the model.
    task automatic step(input logic r, input logic w, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic bs, input logic [AW-1:0] ba,
                        input logic [NR-1:0] ren, input logic [NR*AW-1:0] ra);
        exp_t e;
        rst = r; we = w; waddr = wa; wdata = wd;
        busy_set = bs; busy_addr = ba; re = ren; raddr = ra;
        e.rdy = m_ready;
        e.rb  = '0;
        e.rd  = '0;
        for (int p = 0; p < NR; p++) begin
            logic [AW-1:0] a;
            bit            hit;
            a   = ra[p*AW +: AW];
            hit = BYP && w && (wa == a);
            if (m_ready && ren[p] && a != 0) begin
                e.rd[p*DW +: DW] = hit ? wd : m_mem[a];
            end
            e.rb[p] = m_ready && ren[p] && m_busy[a] && !hit;
        end
        q.push_back(e);
        @(posedge clk);
        if (!r) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            for (int k = 0; k < DEPTH; k++) begin
                m_busy[k] = 1'b0;
                m_mem[k]  = '0;
            end
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == DEPTH) m_ready = 1'b1;
        end else begin
            if (w && wa != 0) m_mem[wa] = wd;
            if (w) m_busy[wa] = 1'b0;
            if (bs && ba != 0) m_busy[ba] = 1'b1;
        end
        #1;
    endtask

    function automatic logic [NR*AW-1:0] addrs(input int a0, input int a1, input int a2, input int a3);
        logic [NR*AW-1:0] v;
        v = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
        return v;
    endfunction

    // Monitor: compare whatever the DUT presents against the oldest prediction.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (ready !== e.rdy) begin
                failures++;
                $display("FAIL ready txn=%0d got=%b exp=%b", txn, ready, e.rdy);
            end
            checks++;
            if (rbusy !== e.rb) begin
                failures++;
                $display("FAIL rbusy txn=%0d got=%b exp=%b", txn, rbusy, e.rb);
            end
            for (int p = 0; p < NR; p++) begin
                checks++;
                if (rdata[p*DW +: DW] !== e.rd[p*DW +: DW]) begin
                    failures++;
                    $display("FAIL rdata%0d txn=%0d got=%h exp=%h", p, txn,
                             rdata[p*DW +: DW], e.rd[p*DW +: DW]);
                end
            end
            $display("txn %0d rst=%b we=%b wa=%0d ra=%h re=%b ready=%b rbusy=%b rd0=%h",
                     txn, rst, we, waddr, raddr, re, ready, rbusy, rdata[DW-1:0]);
            txn++;
        end
    end

    initial begin
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        busy_set = 1'b0; busy_addr = '0; re = '0; raddr = '0;
        m_ready = 1'b0; m_cnt = 0;
        for (int k = 0; k < DEPTH; k++) begin
            m_busy[k] = 1'b0;
            m_mem[k]  = '0;
        end
        @(posedge clk); #1;

        // Reset held, then release and walk through the clear sequence.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 4'hF, addrs(1, 2, 3, 4));
        for (int i = 0; i < DEPTH + 2; i++)
            step(1, 0, 0, 0, 0, 0, 4'hF, addrs(1 + (i % 31), 31 - (i % 31), 5, 8));

        // Write r5 with same-cycle read, then read again.
        step(1, 1, 5, 64'hDEADBEEF, 0, 0, 4'b0011, addrs(5, 5, 0, 0));
        step(1, 0, 0, 0, 0, 0, 4'b0011, addrs(5, 5, 0, 0));

        // r0 is hardwired: writes and busy marks have no effect.
        step(1, 1, 0, 64'h12345678, 1, 0, 4'b0011, addrs(0, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, 4'b0011, addrs(0, 0, 0, 0));

        // Busy scoreboard on r8: set, set+clear same cycle, lone clear.
        step(1, 0, 0, 0, 1, 8, 4'b0001, addrs(8, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, 4'b0001, addrs(8, 0, 0, 0));
        step(1, 1, 8, 64'h1111, 1, 8, 4'b0001, addrs(8, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, 4'b0001, addrs(8, 0, 0, 0));
        step(1, 1, 8, 64'h2222, 0, 0, 4'b0001, addrs(8, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, 4'b0001, addrs(8, 0, 0, 0));

        // Four distinct 64-bit values read concurrently; port 2 disabled.
        step(1, 1, 10, 64'h0123456789ABCDEF, 0, 0, 4'b0000, 0);
        step(1, 1, 11, 64'hFEDCBA9876543210, 0, 0, 4'b0000, 0);
        step(1, 1, 12, 64'hCAFEF00DBAADC0DE, 0, 0, 4'b0000, 0);
        step(1, 1, 13, 64'h5555AAAA3333CCCC, 0, 0, 4'b0000, 0);
        step(1, 0, 0, 0, 0, 0, 4'b1111, addrs(10, 11, 12, 13));
        step(1, 0, 0, 0, 0, 0, 4'b1011, addrs(10, 11, 12, 13));

        // Mid-RUN reset clears contents and pending busy marks.
        step(1, 1, 3, 64'hA5A5A5A5, 1, 9, 4'b0000, 0);
        step(1, 0, 0, 0, 0, 0, 4'b0011, addrs(3, 9, 0, 0));
        step(0, 0, 0, 0, 0, 0, 4'b0011, addrs(3, 9, 0, 0));
        for (int i = 0; i < DEPTH + 2; i++) step(1, 0, 0, 0, 0, 0, 4'b0011, addrs(3, 9, 0, 0));

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 700; i++) begin
            logic             r, w, bs;
            logic [AW-1:0]    wa, ba;
            logic [DW-1:0]    wd;
            logic [NR-1:0]    ren;
            logic [NR*AW-1:0] ra;
            r   = ($urandom_range(0, 299) != 0);
            w   = ($urandom_range(0, 1) == 1);
            wa  = AW'($urandom_range(0, DEPTH - 1));
            wd  = {$urandom, $urandom};
            bs  = ($urandom_range(0, 3) == 0);
            ba  = ($urandom_range(0, 1) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
            ren = NR'($urandom_range(0, 15));
            for (int p = 0; p < NR; p++)
                ra[p*AW +: AW] = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
            step(r, w, wa, wd, bs, ba, ren, ra);
        end

        @(negedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
